// File: rtl/ddr3_ram_arb.sv
// ddr3_ram_arb: N-port round-robin arbiter merging RAM-interface requesters onto one ddr3_core port.
// Optional build macro DDR3_ARB_PRIO0_EN gives port 0 strict priority over the round-robin ports.
module ddr3_ram_arb #(
    parameter int PORTS           = 4,
    parameter int MAX_OUTSTANDING = 8,
    localparam int SEL_W          = $clog2(PORTS),
    localparam int PID_W          = 17 - SEL_W
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [PORTS-1:0][15:0]           port_wr_i,
    input  logic [PORTS-1:0]                 port_rd_i,
    input  logic [PORTS-1:0][PID_W-1:0]      port_req_id_i,
    input  logic [PORTS-1:0][31:0]           port_addr_i,
    input  logic [PORTS-1:0][127:0]          port_write_data_i,
    output logic [PORTS-1:0]                 port_accept_o,
    output logic [PORTS-1:0]                 port_ack_o,
    output logic [PORTS-1:0]                 port_error_o,
    output logic [127:0]                     port_read_data_o,
    output logic [PID_W-1:0]                 port_resp_id_o,
    output logic [15:0]                      ram_wr_o,
    output logic                             ram_rd_o,
    output logic [16:0]                      ram_req_id_o,
    output logic [31:0]                      ram_addr_o,
    output logic [127:0]                     ram_write_data_o,
    input  logic                             ram_accept_i,
    input  logic                             ram_ack_i,
    input  logic                             ram_error_i,
    input  logic [127:0]                     ram_read_data_i,
    input  logic [16:0]                      ram_resp_id_i
);
    logic [SEL_W-1:0]       last_grant, grant, idx, sel;
    logic                   grant_valid, grant_upd, free;
    logic [PORTS-1:0]       elig, rr_elig, dec;
    logic [PORTS-1:0][3:0]  cnt;

    // The hold register is occupied exactly when it carries a read or any write strobe.
    assign sel              = ram_resp_id_i[16 -: SEL_W];
    assign free             = !(|ram_wr_o || ram_rd_o) || ram_accept_i;
    assign port_read_data_o = ram_read_data_i;
    assign port_resp_id_o   = ram_resp_id_i[PID_W-1:0];

    // Eligibility and response demux; an ack on a port frees its slot in the same cycle.
    always_comb begin
        elig         = '0;
        dec          = '0;
        port_ack_o   = '0;
        port_error_o = '0;
        for (int p = 0; p < PORTS; p++) begin
            port_ack_o[p]   = ram_ack_i && sel == SEL_W'(p);
            port_error_o[p] = ram_error_i && sel == SEL_W'(p);
            dec[p]          = port_ack_o[p] && cnt[p] != 4'd0;
            elig[p]         = (|port_wr_i[p] || port_rd_i[p]) && (cnt[p] < 4'(MAX_OUTSTANDING) || dec[p]);
        end
    end

    // Round-robin search from last_grant+1; scanning backwards lets the nearest port win.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
`ifdef DDR3_ARB_PRIO0_EN
        rr_elig = elig & ~PORTS'(1);
`else
        rr_elig = elig;
`endif
        for (int i = PORTS; i >= 1; i--) begin
            idx = SEL_W'((int'(last_grant) + i) % PORTS);
            if (rr_elig[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
`ifdef DDR3_ARB_PRIO0_EN
        if (elig[0]) begin
            grant       = '0;
            grant_valid = 1'b1;
        end
        grant_upd = grant_valid && grant != '0;
`else
        grant_upd = grant_valid;
`endif
        port_accept_o = (grant_valid && free && rst_i) ? PORTS'(1) << grant : '0;
    end

    // Hold register, round-robin pointer and per-port outstanding counters.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ram_wr_o         <= '0;
            ram_rd_o         <= 1'b0;
            ram_req_id_o     <= '0;
            ram_addr_o       <= '0;
            ram_write_data_o <= '0;
            last_grant       <= SEL_W'(PORTS - 1);
            cnt              <= '0;
        end else begin
            if (|port_accept_o) begin
                ram_wr_o         <= port_wr_i[grant];
                ram_rd_o         <= port_rd_i[grant];
                ram_req_id_o     <= {grant, port_req_id_i[grant]};
                ram_addr_o       <= port_addr_i[grant];
                ram_write_data_o <= port_write_data_i[grant];
                last_grant       <= grant_upd ? grant : last_grant;
            end else if (ram_accept_i) begin
                ram_wr_o <= '0;
                ram_rd_o <= 1'b0;
            end
            for (int p = 0; p < PORTS; p++)
                cnt[p] <= cnt[p] + {3'b0, port_accept_o[p]} - {3'b0, dec[p]};
        end
    end
endmodule

// File: tb/tb_ddr3_ram_arb.sv
// tb_ddr3_ram_arb: directed self-checking bench for ddr3_ram_arb with PORTS=4, MAX_OUTSTANDING=2.
module tb_ddr3_ram_arb;
    localparam int PORTS = 4;
    localparam int PID_W = 15;

    logic                        clk = 1'b0;
    logic                        rst_i = 1'b0;
    logic [PORTS-1:0][15:0]      port_wr_i = '0;
    logic [PORTS-1:0]            port_rd_i = '0;
    logic [PORTS-1:0][PID_W-1:0] port_req_id_i = '0;
    logic [PORTS-1:0][31:0]      port_addr_i = '0;
    logic [PORTS-1:0][127:0]     port_write_data_i = '0;
    logic [PORTS-1:0]            port_accept_o, port_ack_o, port_error_o;
    logic [127:0]                port_read_data_o;
    logic [PID_W-1:0]            port_resp_id_o;
    logic [15:0]                 ram_wr_o;
    logic                        ram_rd_o;
    logic [16:0]                 ram_req_id_o;
    logic [31:0]                 ram_addr_o;
    logic [127:0]                ram_write_data_o;
    logic                        ram_accept_i = 1'b1;
    logic                        ram_ack_i = 1'b0;
    logic                        ram_error_i = 1'b0;
    logic [127:0]                ram_read_data_i = '0;
    logic [16:0]                 ram_resp_id_i = '0;

    int n_checks = 0;
    int n_fail   = 0;

    ddr3_ram_arb #(.PORTS(PORTS), .MAX_OUTSTANDING(2)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .port_wr_i(port_wr_i), .port_rd_i(port_rd_i), .port_req_id_i(port_req_id_i),
        .port_addr_i(port_addr_i), .port_write_data_i(port_write_data_i),
        .port_accept_o(port_accept_o), .port_ack_o(port_ack_o), .port_error_o(port_error_o),
        .port_read_data_o(port_read_data_o), .port_resp_id_o(port_resp_id_o),
        .ram_wr_o(ram_wr_o), .ram_rd_o(ram_rd_o), .ram_req_id_o(ram_req_id_o),
        .ram_addr_o(ram_addr_o), .ram_write_data_o(ram_write_data_o),
        .ram_accept_i(ram_accept_i), .ram_ack_i(ram_ack_i), .ram_error_i(ram_error_i),
        .ram_read_data_i(ram_read_data_i), .ram_resp_id_i(ram_resp_id_i)
    );

    always #5 clk = ~clk;

    // Every port carries a distinct, recognisable id/address/data pattern.
    function automatic logic [16:0] exp_id(int p);
        exp_id = {2'(p), 15'h100 + 15'(p)};
    endfunction

    task automatic clear_inputs;
        port_wr_i       = '0;
        port_rd_i       = '0;
        ram_accept_i    = 1'b1;
        ram_ack_i       = 1'b0;
        ram_error_i     = 1'b0;
        ram_resp_id_i   = '0;
        ram_read_data_i = '0;
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        rst_i = 1'b0;
        clear_inputs();
        @(posedge clk); #1;
        rst_i = 1'b1;
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        rst_i = 1'b0;
        port_rd_i = '1;
        @(negedge clk);
        n_checks++;
        if (port_accept_o !== 4'b0000) begin n_fail++; $display("FAIL reset_accept got=%b exp=0000", port_accept_o); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (ram_rd_o !== 1'b0 || ram_wr_o !== 16'h0) begin n_fail++; $display("FAIL reset_rdwr got rd=%b wr=%h exp 0", ram_rd_o, ram_wr_o); end
        n_checks++;
        if (ram_req_id_o !== 17'h0 || ram_addr_o !== 32'h0 || ram_write_data_o !== 128'h0) begin
            n_fail++; $display("FAIL reset_fields got id=%h addr=%h data=%h exp 0", ram_req_id_o, ram_addr_o, ram_write_data_o);
        end
        n_checks++;
        if (port_ack_o !== 4'b0 || port_error_o !== 4'b0) begin n_fail++; $display("FAIL reset_ack got ack=%b err=%b exp 0", port_ack_o, port_error_o); end
    endtask

    task automatic test_round_robin;
        do_reset();
        port_rd_i = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (port_accept_o !== 4'(1 << (k % 4))) begin
                n_fail++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, port_accept_o, 4'(1 << (k % 4)));
            end
            if (k >= 1) begin
                n_checks++;
                if (ram_req_id_o !== exp_id((k - 1) % 4) || ram_rd_o !== 1'b1) begin
                    n_fail++; $display("FAIL rr_id k=%0d got=%h rd=%b exp=%h", k, ram_req_id_o, ram_rd_o, exp_id((k - 1) % 4));
                end
                n_checks++;
                if (ram_addr_o !== 32'h1000 * ((k - 1) % 4 + 1) || ram_write_data_o !== {4{32'hA0 + 32'((k - 1) % 4)}}) begin
                    n_fail++; $display("FAIL rr_payload k=%0d got addr=%h data=%h", k, ram_addr_o, ram_write_data_o);
                end
            end
            @(posedge clk); #1;
            ram_ack_i     = 1'b1;
            ram_resp_id_i = {2'(k % 4), 15'h0};
        end
        clear_inputs();
    endtask

    task automatic test_back_pressure;
        logic [3:0]  second;
        logic [16:0] second_id;
`ifdef DDR3_ARB_PRIO0_EN
        second    = 4'b0001;
        second_id = exp_id(0);
`else
        second    = 4'b0010;
        second_id = exp_id(1);
`endif
        do_reset();
        port_rd_i    = '1;
        ram_accept_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (port_accept_o !== 4'b0001) begin n_fail++; $display("FAIL bp_first got=%b exp=0001", port_accept_o); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++;
            if (port_accept_o !== 4'b0000) begin n_fail++; $display("FAIL bp_stall k=%0d got=%b exp=0000", k, port_accept_o); end
            n_checks++;
            if (ram_req_id_o !== exp_id(0) || ram_rd_o !== 1'b1 || ram_addr_o !== 32'h1000) begin
                n_fail++; $display("FAIL bp_stable k=%0d got id=%h rd=%b addr=%h", k, ram_req_id_o, ram_rd_o, ram_addr_o);
            end
        end
        @(posedge clk); #1;
        ram_accept_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (port_accept_o !== second) begin n_fail++; $display("FAIL bp_release got=%b exp=%b", port_accept_o, second); end
        @(posedge clk); #1;
        port_rd_i = '0;
        @(negedge clk);
        n_checks++;
        if (ram_req_id_o !== second_id) begin n_fail++; $display("FAIL bp_next_id got=%h exp=%h", ram_req_id_o, second_id); end
        clear_inputs();
    endtask

    task automatic test_outstanding;
        logic [3:0] exp_acc [6] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
        do_reset();
        port_rd_i[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ram_ack_i     = (k == 3 || k == 4);
            ram_resp_id_i = (k == 3) ? {2'd2, 15'h0} : {2'd1, 15'h0};
            @(negedge clk);
            n_checks++;
            if (port_accept_o !== exp_acc[k]) begin n_fail++; $display("FAIL outst_accept k=%0d got=%b exp=%b", k, port_accept_o, exp_acc[k]); end
            if (k == 3 || k == 4) begin
                n_checks++;
                if (port_ack_o !== (k == 3 ? 4'b0100 : 4'b0010)) begin
                    n_fail++; $display("FAIL outst_ack k=%0d got=%b exp=%b", k, port_ack_o, (k == 3 ? 4'b0100 : 4'b0010));
                end
            end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_routing;
        @(posedge clk); #1;
        ram_ack_i       = 1'b1;
        ram_error_i     = 1'b1;
        ram_resp_id_i   = {2'd2, 15'h1234};
        ram_read_data_i = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        #1;
        n_checks++;
        if (port_ack_o !== 4'b0100 || port_error_o !== 4'b0100) begin
            n_fail++; $display("FAIL route_ack got ack=%b err=%b exp 0100/0100", port_ack_o, port_error_o);
        end
        n_checks++;
        if (port_resp_id_o !== 15'h1234 || port_read_data_o !== 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE) begin
            n_fail++; $display("FAIL route_data got id=%h data=%h", port_resp_id_o, port_read_data_o);
        end
        ram_error_i   = 1'b0;
        ram_resp_id_i = {2'd3, 15'h0042};
        #1;
        n_checks++;
        if (port_ack_o !== 4'b1000 || port_error_o !== 4'b0000 || port_resp_id_o !== 15'h0042) begin
            n_fail++; $display("FAIL route_noerr got ack=%b err=%b id=%h", port_ack_o, port_error_o, port_resp_id_o);
        end
        ram_ack_i = 1'b0;
        #1;
        n_checks++;
        if (port_ack_o !== 4'b0000) begin n_fail++; $display("FAIL route_idle got=%b exp=0000", port_ack_o); end
        clear_inputs();
    endtask

    task automatic test_passthrough;
        do_reset();
        port_wr_i[2] = 16'hF0F0;
        port_rd_i[2] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (port_accept_o !== 4'b0100) begin n_fail++; $display("FAIL pass_accept got=%b exp=0100", port_accept_o); end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (ram_wr_o !== 16'hF0F0 || ram_rd_o !== 1'b1 || ram_req_id_o !== exp_id(2)) begin
            n_fail++; $display("FAIL pass_fields got wr=%h rd=%b id=%h", ram_wr_o, ram_rd_o, ram_req_id_o);
        end
    endtask

    task automatic test_simul_and_reset;
        logic [3:0] exp_acc [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
        do_reset();
        port_rd_i[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ram_ack_i     = (k == 1);
            ram_resp_id_i = {2'd0, 15'h0};
            @(negedge clk);
            n_checks++;
            if (port_accept_o !== exp_acc[k]) begin n_fail++; $display("FAIL simul_accept k=%0d got=%b exp=%b", k, port_accept_o, exp_acc[k]); end
            @(posedge clk); #1;
        end
        port_rd_i = '1;
        ram_ack_i = 1'b0;
        rst_i     = 1'b0;
        @(negedge clk);
        n_checks++;
        if (port_accept_o !== 4'b0000) begin n_fail++; $display("FAIL midrst_accept got=%b exp=0000", port_accept_o); end
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ram_rd_o !== 1'b0 || ram_wr_o !== 16'h0) begin n_fail++; $display("FAIL midrst_hold got rd=%b wr=%h exp 0", ram_rd_o, ram_wr_o); end
        n_checks++;
        if (port_accept_o !== 4'b0001) begin n_fail++; $display("FAIL midrst_grant got=%b exp=0001", port_accept_o); end
        clear_inputs();
    endtask

`ifdef DDR3_ARB_PRIO0_EN
    task automatic test_prio0;
        logic [3:0] exp_acc [5] = '{4'b0001, 4'b0001, 4'b1000, 4'b1000, 4'b0000};
        do_reset();
        port_rd_i[0] = 1'b1;
        port_rd_i[3] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (port_accept_o !== exp_acc[k]) begin n_fail++; $display("FAIL prio_accept k=%0d got=%b exp=%b", k, port_accept_o, exp_acc[k]); end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask
`endif

    initial begin
        for (int p = 0; p < PORTS; p++) begin
            port_req_id_i[p]     = 15'h100 + 15'(p);
            port_addr_i[p]       = 32'h1000 * (p + 1);
            port_write_data_i[p] = {4{32'hA0 + 32'(p)}};
        end
        test_reset();
`ifdef DDR3_ARB_PRIO0_EN
        test_prio0();
`else
        test_round_robin();
`endif
        test_back_pressure();
        test_outstanding();
        test_routing();
        test_passthrough();
        test_simul_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ddr3_ram_arb.md
# ddr3_ram_arb

Parametrised N-port arbiter that merges several 128-bit RAM-interface requesters (AXI bridges, DMA engines) onto the single RAM-interface port of the DDR3 core. It tags each request ID with the winning port index, enforces a per-port outstanding-request limit, and routes acks, errors and read data back to the originating port. It sits between multiple `ddr3_axi_pmem`-class bridges and `ddr3_core`.

## Interface
Parameters:
- `PORTS`, 4: number of requester ports, 2..8.
- `MAX_OUTSTANDING`, 8: maximum in-flight requests per port, 1..15.
- Localparams: `SEL_W` = clog2(PORTS); `PID_W` = 17 − SEL_W, the port-side ID width.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-low.
- `port_wr_i` in PORTS×16: per-port byte write strobes.
- `port_rd_i` in PORTS: per-port read request.
- `port_req_id_i` in PORTS×PID_W: per-port request ID.
- `port_addr_i` in PORTS×32: per-port byte address, 16-byte aligned.
- `port_write_data_i` in PORTS×128: per-port write data.
- `port_accept_o` out PORTS: request accepted this cycle.
- `port_ack_o` out PORTS: response valid for this port.
- `port_error_o` out PORTS: response error for this port.
- `port_read_data_o` out 128: read data, shared by all ports.
- `port_resp_id_o` out PID_W: response ID, shared by all ports.
- `ram_wr_o` out 16, `ram_rd_o` out 1, `ram_req_id_o` out 17, `ram_addr_o` out 32, `ram_write_data_o` out 128: request to the core.
- `ram_accept_i` in 1: core accepts the current request.
- `ram_ack_i` in 1, `ram_error_i` in 1, `ram_read_data_i` in 128, `ram_resp_id_i` in 17: response from the core.

## Operation
- A port is requesting when `|port_wr_i[p] | port_rd_i[p]`. It is eligible when it is requesting and `outstanding[p] < MAX_OUTSTANDING`.
- One-entry output register, `hold`, drives the `ram_*` request outputs. `hold` is free when it is empty, or when it is full and `ram_accept_i`=1.
- When `hold` is free and any port is eligible, the arbiter grants one port `g`:
  - `port_accept_o[g]`=1 in the same cycle.
  - `hold` loads wr, rd, addr and data unchanged, with `ram_req_id_o` = {g[SEL_W-1:0], port_req_id_i[g]}.
- Round-robin: search starts at `last_grant+1` and wraps modulo PORTS. `last_grant` updates on each grant. Reset value of `last_grant` is PORTS−1, so port 0 wins first.
- A request with both wr≠0 and rd=1 is passed through unchanged; the arbiter does not interpret it.
- Outstanding counters, one per port, 4 bits each:
  - +1 on accept of that port.
  - −1 on `ram_ack_i` with `ram_resp_id_i[16 -: SEL_W]`==p.
  - Accept and ack in the same cycle: counter unchanged.
  - An ack that arrives when the counter is 0 is ignored; the counter saturates at 0.
- Response routing is combinational:
  - `port_ack_o[p]` = ram_ack_i & (sel==p).
  - `port_error_o[p]` = ram_error_i & (sel==p).
  - `port_read_data_o` = ram_read_data_i.
  - `port_resp_id_o` = ram_resp_id_i[PID_W-1:0].
  - An ack whose sel ≥ PORTS is dropped and no port is acked.
- Mid-operation reset: `hold` is cleared, all counters return to 0, and `last_grant` returns to PORTS−1. Acks for requests issued before reset hit the saturation-at-0 rule and are ignored.

## Timing
- Reset values:
  - `port_accept_o`=0.
  - `ram_wr_o`=0, `ram_rd_o`=0, `ram_req_id_o`=0, `ram_addr_o`=0, `ram_write_data_o`=0.
  - `port_ack_o`/`port_error_o` follow their inputs; they are 0 when `ram_ack_i`=0.
- Request latency: a grant in cycle N puts `ram_*` valid in cycle N+1.
- Sustained throughput is 1 request per cycle while `ram_accept_i`=1.
- `ram_*` outputs hold stable while the request is not accepted.
- `port_accept_o` depends combinationally on `ram_accept_i` and `port_*` inputs, not on any `port_*` output.
- Response path latency is 0 cycles.

## Configuration
- `DDR3_ARB_PRIO0_EN` defined: port 0 has strict priority. It wins whenever it is eligible and does not update `last_grant`. Ports 1..PORTS−1 are served round-robin among themselves.
- `DDR3_ARB_PRIO0_EN` undefined: pure round-robin across all ports, as described in Operation.

## Test plan
- Round-robin fairness: PORTS=4, all ports request continuously, `ram_accept_i`=1 → grant order 0,1,2,3,0,… one per cycle. `ram_req_id_o[16:15]` matches the granted port.
- Back-pressure: `ram_accept_i`=0 for 5 cycles → `ram_*` stable, no `port_accept_o`. Then `ram_accept_i`=1 → a new grant in the same cycle.
- Outstanding limit: MAX_OUTSTANDING=2, port 1 issues 3 reads, no acks → third read not accepted until an ack with resp_id[16:15]=1 arrives. The third read is then accepted in that same cycle.
- Response routing: `ram_ack_i`=1, `ram_resp_id_i`={2'd2, 15'h1234}, `ram_error_i`=1 → `port_ack_o`=4'b0100, `port_error_o`=4'b0100, `port_resp_id_o`=15'h1234.
- Simultaneous accept and ack on port 0 with counter=1 → counter stays 1. Then assert `rst_i`=0 for 1 cycle mid-burst → counters 0, `ram_rd_o`=0, `ram_wr_o`=0, and the next grant goes to port 0.
- With `DDR3_ARB_PRIO0_EN`: ports 0 and 3 request continuously → port 0 is granted every cycle and port 3 only when port 0 hits its limit.
